// File: rtl/program_loader.sv
// program_loader
//   Writer side of the nRISC instruction/data memory port. Takes a framed byte
//   stream (length, payload, checksum) over a valid/ready handshake. It writes
//   the payload into memory from address 0 upward. The CPU stays halted until
//   a load finishes with a good checksum.
//
// Ports
//   c          clock, rising edge
//   rst        asynchronous reset, active-high
//   start      begin-load request
//   in_valid   stream byte valid
//   in_data    stream byte
//   in_ready   loader can accept a byte (decoded from state)
//   mem_we     memory write enable, one registered pulse per payload byte
//   mem_addr   memory write address
//   mem_wdata  memory write data
//   cpu_halt   1 = CPU held, 0 = CPU runs (only in DONE)
//   done       load finished, checksum good
//   error      load aborted, bad length or bad checksum
//   count      payload bytes written in the current load
module program_loader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              c,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_halt,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // LEN   | waiting for the length byte
  // LOAD  | accepting payload bytes and writing them to memory
  // CHECK | waiting for the checksum byte
  // DONE  | load good, CPU released
  // ERR   | load aborted, CPU held
  typedef enum logic [2:0] {IDLE, LEN, LOAD, CHECK, DONE, ERR} state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state, state_nx;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   in_ext;
  logic [ADDR_W:0]   count_inc;
  logic              accept;
  logic              len_bad;

  assign accept    = in_valid && in_ready;
  assign in_ext    = (ADDR_W+1)'(in_data);
  assign len_bad   = (in_ext == '0) || (in_ext > DEPTH);
  assign count_inc = count + (ADDR_W+1)'(1);

  always_ff @(posedge c or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_halt = 1'b1;
    case (state)
      IDLE: if (start) state_nx = LEN;
      LEN: begin
        in_ready = 1'b1;
        if (accept) state_nx = len_bad ? ERR : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        // the byte that brings count up to len is the last payload byte
        if (accept && (count_inc == len)) state_nx = CHECK;
      end
      CHECK: begin
        in_ready = 1'b1;
        if (accept) state_nx = (in_data == sum) ? DONE : ERR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_halt = 1'b0;
        if (start) state_nx = LEN;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_nx = LEN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sum       <= '0;
      len       <= '0;
      count     <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        LEN: begin
          if (accept && !len_bad) begin
            len   <= in_ext;
            count <= '0;
            sum   <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= count[ADDR_W-1:0];
            mem_wdata <= in_data;
            sum       <= sum + in_data;
            count     <= count_inc;
          end
        end
        DONE, ERR: if (start) count <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Self-checking bench for program_loader. It runs directed frames from a
//   table, then a reset-abort sequence, then a maximum-length frame, and then
//   random frames. Expected outcomes come from frame-level arithmetic. Memory
//   writes are checked cycle by cycle against the bytes the bench sent.
module tb_program_loader;

  logic       c = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_we, cpu_halt, done, error;
  logic [7:0] mem_addr, mem_wdata;
  logic [8:0] count;

  int tests = 0;
  int fails = 0;

  logic [7:0] pay [0:255];

  typedef struct {
    logic [7:0] len;
    logic [7:0] p [4];
    logic [7:0] chk;
    int         gap;
    bit         exp_done;
    bit         exp_err;
    int         exp_cnt;
  } vec_t;

  vec_t rows [5];

  program_loader #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256)) dut (
    .c(c), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_halt(cpu_halt), .done(done), .error(error),
    .count(count)
  );

  always #5 c = ~c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " in_ready"},  32'(in_ready), 0);
    chk({tag, " mem_we"},    32'(mem_we), 0);
    chk({tag, " mem_addr"},  32'(mem_addr), 0);
    chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, " cpu_halt"},  32'(cpu_halt), 1);
    chk({tag, " done"},      32'(done), 0);
    chk({tag, " error"},     32'(error), 0);
    chk({tag, " count"},     32'(count), 0);
  endtask

  // Sends one frame starting right after a falling edge. Length byte lb,
  // payload from pay[], checksum ck. gap: 0 none, 1 one idle cycle before
  // every byte, 2 random idle cycles. noise drives random start during the frame.
  task automatic send_frame(input logic [7:0] lb, input logic [7:0] ck, input int gap,
                            input bit noise, input bit exp_done, input bit exp_err,
                            input int exp_cnt, input string tag);
    int total;
    logic [7:0] b;
    total = (lb == 8'd0) ? 1 : int'(lb) + 2;
    // start together with a valid byte: the byte must not be taken
    start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    @(negedge c);
    start = 1'b0; in_valid = 1'b0;
    chk({tag, " halt after start"},  32'(cpu_halt), 1);
    chk({tag, " ready after start"}, 32'(in_ready), 1);
    chk({tag, " done after start"},  32'(done), 0);
    chk({tag, " error after start"}, 32'(error), 0);
    chk({tag, " we after start"},    32'(mem_we), 0);
    for (int i = 0; i < total; i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0; in_data = 8'($urandom); start = noise ? 1'($urandom) : 1'b0;
        @(negedge c);
        chk({tag, " we in gap"}, 32'(mem_we), 0);
      end
      if (i == 0)            b = lb;
      else if (i <= int'(lb)) b = pay[i-1];
      else                   b = ck;
      in_valid = 1'b1; in_data = b; start = noise ? 1'($urandom) : 1'b0;
      chk({tag, " ready in frame"}, 32'(in_ready), 1);
      @(negedge c);
      if (i >= 1 && i <= int'(lb)) begin
        chk({tag, " we"},    32'(mem_we), 1);
        chk({tag, " addr"},  32'(mem_addr), 32'(i - 1));
        chk({tag, " wdata"}, 32'(mem_wdata), 32'(b));
      end else begin
        chk({tag, " no we"}, 32'(mem_we), 0);
      end
    end
    in_valid = 1'b0; start = 1'b0;
    chk({tag, " done"},     32'(done), 32'(exp_done));
    chk({tag, " error"},    32'(error), 32'(exp_err));
    chk({tag, " cpu_halt"}, 32'(cpu_halt), 32'(!exp_done));
    chk({tag, " count"},    32'(count), 32'(exp_cnt));
    chk({tag, " ready end"}, 32'(in_ready), 0);
    // a stray byte in DONE/ERR must be ignored
    in_valid = 1'b1; in_data = 8'($urandom);
    @(negedge c);
    in_valid = 1'b0;
    chk({tag, " no we end"}, 32'(mem_we), 0);
    chk({tag, " done hold"}, 32'(done), 32'(exp_done));
  endtask

  initial begin
    // table: len, payload, checksum, gap mode, done, error, count
    rows[0] = '{len: 8'h03, p: '{8'h11, 8'h22, 8'h33, 8'h00}, chk: 8'h66, gap: 0,
                exp_done: 1, exp_err: 0, exp_cnt: 3};
    rows[1] = '{len: 8'h02, p: '{8'hAA, 8'hBB, 8'h00, 8'h00}, chk: 8'h00, gap: 0,
                exp_done: 0, exp_err: 1, exp_cnt: 2};
    rows[2] = '{len: 8'h00, p: '{8'h00, 8'h00, 8'h00, 8'h00}, chk: 8'h00, gap: 0,
                exp_done: 0, exp_err: 1, exp_cnt: 0};
    rows[3] = '{len: 8'h02, p: '{8'h80, 8'h90, 8'h00, 8'h00}, chk: 8'h10, gap: 1,
                exp_done: 1, exp_err: 0, exp_cnt: 2};
    rows[4] = '{len: 8'h01, p: '{8'hFF, 8'h00, 8'h00, 8'h00}, chk: 8'hFF, gap: 0,
                exp_done: 1, exp_err: 0, exp_cnt: 1};

    #1;
    chk_reset_values("reset");
    @(negedge c);
    rst = 1'b0;
    // IDLE ignores bytes without start
    in_valid = 1'b1; in_data = 8'h03;
    @(negedge c);
    chk("idle ready", 32'(in_ready), 0);
    chk("idle we",    32'(mem_we), 0);
    in_valid = 1'b0;
    @(negedge c);

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) pay[k] = rows[r].p[k];
      send_frame(rows[r].len, rows[r].chk, rows[r].gap, 1'b0, rows[r].exp_done,
                 rows[r].exp_err, rows[r].exp_cnt, $sformatf("row%0d", r));
    end

    // asynchronous reset in the middle of a 4-byte load
    start = 1'b1;
    @(negedge c);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h04;
    @(negedge c);
    in_data = 8'h01;
    @(negedge c);
    in_data = 8'h02;
    @(negedge c);
    in_valid = 1'b0;
    chk("abort pre we",   32'(mem_we), 1);
    chk("abort pre addr", 32'(mem_addr), 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_values("abort");
    @(negedge c);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(negedge c);
      chk("post abort we",    32'(mem_we), 0);
      chk("post abort ready", 32'(in_ready), 0);
      chk("post abort halt",  32'(cpu_halt), 1);
    end
    in_valid = 1'b0;

    // maximum length frame from IDLE
    begin
      int s;
      s = 0;
      for (int k = 0; k < 255; k++) begin
        pay[k] = 8'(k * 7 + 3);
        s = (s + int'(pay[k])) % 256;
      end
      send_frame(8'd255, 8'(s), 0, 1'b1, 1'b1, 1'b0, 255, "maxlen");
    end

    // random frames against a frame-level model
    for (int f = 0; f < 40; f++) begin
      int  n, s;
      bit  good, ok;
      logic [7:0] ck;
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      s = 0;
      for (int k = 0; k < n; k++) begin
        pay[k] = 8'($urandom);
        s = (s + int'(pay[k])) % 256;
      end
      good = ($urandom_range(0, 9) < 7);
      ck   = good ? 8'(s) : (8'(s) ^ 8'($urandom_range(1, 255)));
      ok   = (n != 0) && good;
      send_frame(8'(n), ck, 2, 1'b1, ok, !ok, n, $sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
